escaner_teclado_4x4: RTL and testbench
======================================

// Module: escaner_teclado_4x4
// PURPOSE
//  Input-side counterpart of the multiplexed 7-seg display driver: scans a 4x4 matrix keypad.
//  Drives one row low at a time, reads the columns and debounces press and release.
//  Reports each new key once as a 4-bit code plus a one-clock valid strobe.
//  Its code output feeds the display data inputs and other user logic.
// PARAMETERS
//  n      17     prescaler counter width in bits; must satisfy 2**n > lim
//  lim    99999  prescaler terminal count; one scan tick every lim+1 clocks (1 kHz at 100 MHz)
//  N_DEB  4      consecutive matching tick samples required to accept a press or a release (>=2)
// PORTS
//  i_Clk         in   1  system clock; all logic on the rising edge
//  i_Rst         in   1  synchronous reset, active-high
//  i_Columnas    in   4  keypad columns, active-low with external pull-ups, asynchronous
//  o_Filas       out  4  row drive, active-low, exactly one bit low at all times
//  o_Tecla       out  4  code of the last accepted key = 4*row + column
//  o_Valida      out  1  one-clock pulse when a new key is accepted
//  o_Presionada  out  1  high while the accepted key is held (until release is debounced)
// BEHAVIOUR
//  - Reset values: o_Filas=4'b1110, o_Tecla=0, o_Valida=0, o_Presionada=0.
//    Also on reset: state=SCAN, prescaler=0, debounce count=0, synchronizer=4'b1111.
//  - i_Columnas passes through a 2-flop synchronizer. All decisions use the synchronized value.
//  - Prescaler: counts 0..lim and wraps. tick=1 for one clock when count==lim.
//  - Columns are sampled only on tick, so each row settles for a full tick period.
//  - Column select: the lowest-index low column wins. Other columns are ignored.
//  - FSM states:
//    SCAN: on tick, if any column is low, latch row/col, set count=1 and go to DEB_PRESS.
//      o_Filas stays frozen. Otherwise rotate o_Filas left: 1110->1101->1011->0111->1110.
//    DEB_PRESS: on tick, if the latched column is still low, count++.
//      When count reaches N_DEB, go to PRESSED, load o_Tecla, pulse o_Valida, set o_Presionada=1.
//      If the latched column is high, go to SCAN and advance to the next row. No pulse.
//    PRESSED: on tick, if the latched column is high, set count=1 and go to DEB_REL.
//    DEB_REL: on tick, if the latched column is still high, count++.
//      When count reaches N_DEB, clear o_Presionada, go to SCAN and advance to the next row.
//      If the column is low again, return to PRESSED. No new o_Valida pulse.
//  - Latency: o_Valida and o_Tecla update on the clock edge ending the tick cycle.
//    That tick cycle is the one that takes the N_DEB-th matching sample.
//  - o_Filas is held constant in DEB_PRESS, PRESSED and DEB_REL.
//  - Other keys pressed while one is held are ignored until release is accepted.
//  - o_Tecla holds its last value after release. It changes only with an o_Valida pulse.
//  - Debounce counter width is clog2(N_DEB+1). It saturates and never wraps.
//  - Reset mid-operation: any state returns to reset values next clock. No pending pulse is emitted.
// TESTING (bench: lim=3, N_DEB=3)
//  1. Reset 2 clks, no keys -> outputs at reset values.
//     o_Filas walks 1110,1101,1011,0111,1110, changing every 4 clks.
//  2. Hold key row2/col1 (col1 low when o_Filas[2]=0) -> o_Filas frozen at 1011.
//     One o_Valida pulse after the 3rd sample, o_Tecla=9, o_Presionada=1.
//     Release -> o_Presionada=0 three ticks later, scanning resumes at 0111.
//  3. Press row0/col3 for only 1 tick -> no o_Valida, o_Presionada stays 0, scan continues to 1101.
//  4. Press row1 col0 and col3 together -> o_Tecla=4, exactly one pulse.
//  5. Held key row3/col2, released 1 tick, then pressed again -> no second pulse.
//     o_Presionada stays 1, o_Tecla=14.
//  6. Assert i_Rst during DEB_PRESS (row2/col0) -> next clk: o_Filas=1110, outputs 0, no pulse ever.

Source files
------------

// File: rtl/escaner_teclado_4x4.sv
// escaner_teclado_4x4: 4x4 matrix keypad scanner with press/release debounce.
//
// Drives one keypad row low at a time and samples the columns once per scan tick.
// A key is accepted after N_DEB consecutive low samples and released after N_DEB
// consecutive high samples. Each accepted key is reported once.
//
// Parameters:
//   n      prescaler counter width; 2**n must exceed lim
//   lim    prescaler terminal count; one scan tick every lim+1 clocks
//   N_DEB  matching samples needed to accept a press or a release (>= 2)
//
// Ports:
//   i_Clk         system clock, rising edge
//   i_Rst         synchronous reset, active-high
//   i_Columnas    keypad columns, active-low, asynchronous
//   o_Filas       row drive, active-low, exactly one bit low
//   o_Tecla       code of the last accepted key (4*row + column)
//   o_Valida      one-clock pulse when a new key is accepted
//   o_Presionada  high while the accepted key is held
module escaner_teclado_4x4 #(
    parameter int unsigned n     = 17,
    parameter int unsigned lim   = 99999,
    parameter int unsigned N_DEB = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [3:0] i_Columnas,
    output logic [3:0] o_Filas,
    output logic [3:0] o_Tecla,
    output logic       o_Valida,
    output logic       o_Presionada
);

    localparam int unsigned DW = $clog2(N_DEB + 1);

    typedef enum logic [1:0] {SCAN, DEB_PRESS, PRESSED, DEB_REL} state_t;

    state_t         state_q, state_d;
    logic [3:0]     col_meta_q, col_sync_q;
    logic [n-1:0]   presc_q;
    logic [3:0]     filas_q, filas_d;
    logic [1:0]     fila_q, fila_d;
    logic [1:0]     col_q, col_d;
    logic [DW-1:0]  deb_q, deb_d;
    logic [3:0]     tecla_q, tecla_d;
    logic           valida_q, valida_d;
    logic           pres_q, pres_d;

    logic           tick;
    logic           any_low;
    logic [1:0]     col_sel;
    logic           col_high;
    logic [DW-1:0]  deb_inc;
    logic           deb_done;

    assign tick     = (presc_q == n'(lim));
    assign any_low  = ~&col_sync_q;
    assign col_high = col_sync_q[col_q];
    // Saturating increment: the count never wraps past N_DEB.
    assign deb_inc  = (deb_q == DW'(N_DEB)) ? deb_q : deb_q + DW'(1);
    assign deb_done = (deb_inc == DW'(N_DEB));

    // Lowest-index low column wins; later assignments override earlier ones.
    always_comb begin
        col_sel = 2'd3;
        if (!col_sync_q[2]) col_sel = 2'd2;
        if (!col_sync_q[1]) col_sel = 2'd1;
        if (!col_sync_q[0]) col_sel = 2'd0;
    end

    always_comb begin
        state_d  = state_q;
        filas_d  = filas_q;
        fila_d   = fila_q;
        col_d    = col_q;
        deb_d    = deb_q;
        tecla_d  = tecla_q;
        valida_d = 1'b0;
        pres_d   = pres_q;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (any_low) begin
                        col_d   = col_sel;
                        deb_d   = DW'(1);
                        state_d = DEB_PRESS;
                    end else begin
                        filas_d = {filas_q[2:0], filas_q[3]};
                        fila_d  = fila_q + 2'd1;
                    end
                end
                DEB_PRESS: begin
                    if (!col_high) begin
                        deb_d = deb_inc;
                        if (deb_done) begin
                            state_d  = PRESSED;
                            tecla_d  = {fila_q, col_q};
                            valida_d = 1'b1;
                            pres_d   = 1'b1;
                        end
                    end else begin
                        // Bounce or glitch: abandon and keep scanning from the next row.
                        state_d = SCAN;
                        filas_d = {filas_q[2:0], filas_q[3]};
                        fila_d  = fila_q + 2'd1;
                    end
                end
                PRESSED: begin
                    if (col_high) begin
                        deb_d   = DW'(1);
                        state_d = DEB_REL;
                    end
                end
                DEB_REL: begin
                    if (col_high) begin
                        deb_d = deb_inc;
                        if (deb_done) begin
                            pres_d  = 1'b0;
                            state_d = SCAN;
                            filas_d = {filas_q[2:0], filas_q[3]};
                            fila_d  = fila_q + 2'd1;
                        end
                    end else begin
                        state_d = PRESSED;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            col_meta_q <= 4'b1111;
            col_sync_q <= 4'b1111;
            presc_q    <= '0;
            state_q    <= SCAN;
            filas_q    <= 4'b1110;
            fila_q     <= 2'd0;
            col_q      <= 2'd0;
            deb_q      <= '0;
            tecla_q    <= 4'd0;
            valida_q   <= 1'b0;
            pres_q     <= 1'b0;
        end else begin
            col_meta_q <= i_Columnas;
            col_sync_q <= col_meta_q;
            presc_q    <= tick ? '0 : presc_q + n'(1);
            state_q    <= state_d;
            filas_q    <= filas_d;
            fila_q     <= fila_d;
            col_q      <= col_d;
            deb_q      <= deb_d;
            tecla_q    <= tecla_d;
            valida_q   <= valida_d;
            pres_q     <= pres_d;
        end
    end

    assign o_Filas      = filas_q;
    assign o_Tecla      = tecla_q;
    assign o_Valida     = valida_q;
    assign o_Presionada = pres_q;

endmodule

// File: tb/tb_escaner_teclado_4x4.sv
// tb_escaner_teclado_4x4: self-checking bench for the keypad scanner.
// A keypad model turns the set of held keys into column levels; a tick-level
// reference model predicts rows, key code, strobe and held flag every clock.
module tb_escaner_teclado_4x4;

    localparam int unsigned LIM  = 3;
    localparam int unsigned NDEB = 3;
    localparam int unsigned PER  = LIM + 1;

    localparam int MD_IDLE  = 0;
    localparam int MD_PRESS = 1;
    localparam int MD_HELD  = 2;
    localparam int MD_REL   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  columnas;
    logic [3:0]  filas;
    logic [3:0]  tecla;
    logic        valida;
    logic        presionada;
    logic [15:0] teclas = '0;

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;

    // Reference model state.
    int         m_presc = 0;
    int         m_row   = 0;
    int         m_mode  = MD_IDLE;
    int         m_col   = 0;
    int         m_run   = 0;
    logic [3:0] m_code  = '0;
    logic       m_held  = 1'b0;
    logic       m_pulse = 1'b0;

    always #5 clk = ~clk;

    escaner_teclado_4x4 #(
        .n     (2),
        .lim   (LIM),
        .N_DEB (NDEB)
    ) dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_Columnas   (columnas),
        .o_Filas      (filas),
        .o_Tecla      (tecla),
        .o_Valida     (valida),
        .o_Presionada (presionada)
    );

    // Keypad: a held key pulls its column low while its row is driven low.
    always_comb begin
        columnas = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!filas[r] && teclas[4*r+c]) columnas[c] = 1'b0;
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One scan tick: keys are stable for the whole preceding tick period.
    task automatic model_tick();
        logic [3:0] pc;
        int first;
        pc = teclas[m_row*4 +: 4];
        first = -1;
        for (int c = 3; c >= 0; c--) if (pc[c]) first = c;
        case (m_mode)
            MD_IDLE: begin
                if (first >= 0) begin
                    m_col  = first;
                    m_run  = 1;
                    m_mode = MD_PRESS;
                end else begin
                    m_row = (m_row + 1) % 4;
                end
            end
            MD_PRESS: begin
                if (pc[m_col]) begin
                    m_run++;
                    if (m_run == NDEB) begin
                        m_mode  = MD_HELD;
                        m_code  = 4'(4 * m_row + m_col);
                        m_pulse = 1'b1;
                        m_held  = 1'b1;
                    end
                end else begin
                    m_mode = MD_IDLE;
                    m_row  = (m_row + 1) % 4;
                end
            end
            MD_HELD: begin
                if (!pc[m_col]) begin
                    m_run  = 1;
                    m_mode = MD_REL;
                end
            end
            MD_REL: begin
                if (!pc[m_col]) begin
                    m_run++;
                    if (m_run == NDEB) begin
                        m_held = 1'b0;
                        m_mode = MD_IDLE;
                        m_row  = (m_row + 1) % 4;
                    end
                end else begin
                    m_mode = MD_HELD;
                end
            end
            default: ;
        endcase
    endtask

    task automatic model_edge();
        m_pulse = 1'b0;
        if (rst) begin
            m_presc = 0;
            m_row   = 0;
            m_mode  = MD_IDLE;
            m_run   = 0;
            m_code  = '0;
            m_held  = 1'b0;
        end else if (m_presc == LIM) begin
            m_presc = 0;
            model_tick();
        end else begin
            m_presc++;
        end
    endtask

    task automatic clk_step();
        logic [3:0] ef;
        @(posedge clk);
        #1;
        model_edge();
        ef = 4'b1111;
        ef[m_row] = 1'b0;
        if (valida) pulses++;
        check_eq("filas", 16'(filas), 16'(ef));
        check_eq("tecla", 16'(tecla), 16'(m_code));
        check_eq("valida", 16'(valida), 16'(m_pulse));
        check_eq("presionada", 16'(presionada), 16'(m_held));
    endtask

    task automatic run_ticks(input int k);
        repeat (k * PER) clk_step();
    endtask

    initial begin
        int p0;
        bit found;
        logic [15:0] t;

        // 1: reset and idle row walk.
        rst = 1'b1;
        clk_step();
        clk_step();
        check_eq("rst_filas", 16'(filas), 16'h000e);
        check_eq("rst_tecla", 16'(tecla), 16'h0000);
        check_eq("rst_pres", 16'(presionada), 16'h0000);
        rst = 1'b0;
        run_ticks(4);
        check_eq("walk_back", 16'(filas), 16'h000e);

        // 2: key row2/col1 held, then released.
        p0 = pulses;
        teclas = 16'(1) << 9;
        run_ticks(10);
        check_eq("s2_filas", 16'(filas), 16'h000b);
        check_eq("s2_tecla", 16'(tecla), 16'd9);
        check_eq("s2_pres", 16'(presionada), 16'd1);
        check_eq("s2_pulses", 16'(pulses - p0), 16'd1);
        teclas = '0;
        run_ticks(NDEB);
        check_eq("s2_rel", 16'(presionada), 16'd0);
        check_eq("s2_resume", 16'(filas), 16'h0007);
        check_eq("s2_hold", 16'(tecla), 16'd9);

        // 3: one-tick press on row0/col3 is rejected.
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (filas == 4'b1110 && m_mode == MD_IDLE) found = 1'b1;
            else run_ticks(1);
        end
        check_eq("s3_align", 16'(found), 16'd1);
        p0 = pulses;
        teclas = 16'(1) << 3;
        run_ticks(1);
        teclas = '0;
        run_ticks(1);
        check_eq("s3_filas", 16'(filas), 16'h000d);
        check_eq("s3_pres", 16'(presionada), 16'd0);
        run_ticks(4);
        check_eq("s3_pulses", 16'(pulses - p0), 16'd0);

        // 4: two keys on row1, lowest column wins.
        p0 = pulses;
        teclas = (16'(1) << 4) | (16'(1) << 7);
        run_ticks(10);
        check_eq("s4_tecla", 16'(tecla), 16'd4);
        check_eq("s4_pulses", 16'(pulses - p0), 16'd1);
        teclas = '0;
        run_ticks(6);

        // 5: held key with a one-tick release bounce.
        p0 = pulses;
        teclas = 16'(1) << 14;
        run_ticks(10);
        teclas = '0;
        run_ticks(1);
        teclas = 16'(1) << 14;
        run_ticks(5);
        check_eq("s5_pulses", 16'(pulses - p0), 16'd1);
        check_eq("s5_pres", 16'(presionada), 16'd1);
        check_eq("s5_tecla", 16'(tecla), 16'd14);
        teclas = '0;
        run_ticks(6);

        // 6: reset while debouncing a press on row2/col0.
        p0 = pulses;
        teclas = 16'(1) << 8;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            run_ticks(1);
            if (m_mode == MD_PRESS && filas == 4'b1011) found = 1'b1;
        end
        check_eq("s6_reach", 16'(found), 16'd1);
        clk_step();
        rst = 1'b1;
        teclas = '0;
        clk_step();
        check_eq("s6_filas", 16'(filas), 16'h000e);
        check_eq("s6_valida", 16'(valida), 16'd0);
        check_eq("s6_pres", 16'(presionada), 16'd0);
        rst = 1'b0;
        run_ticks(8);
        check_eq("s6_pulses", 16'(pulses - p0), 16'd0);

        // Randomized press/hold/release episodes with occasional bounces.
        for (int ep = 0; ep < 60; ep++) begin
            t = 16'(1) << $urandom_range(15);
            if ($urandom_range(3) == 0) t |= 16'(1) << $urandom_range(15);
            teclas = t;
            run_ticks(int'($urandom_range(1, 8)));
            if ($urandom_range(2) == 0) begin
                teclas = '0;
                run_ticks(int'($urandom_range(1, 2)));
                teclas = t;
                run_ticks(int'($urandom_range(1, 4)));
            end
            teclas = '0;
            run_ticks(int'($urandom_range(1, 6)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
